// File: rtl/scalar_ladder_seq.sv
// rtl/scalar_ladder_seq.sv - scalar ladder step sequencer, MSB-first walk with command handshake
module scalar_ladder_seq #(
  parameter int N  = 255,
  parameter int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [N-1:0]  k,
  input  logic          abort,
  output logic [N-1:0]  k_q,
  output logic          enc_en,
  input  logic [IW-1:0] msb,
  output logic          cmd_vld,
  input  logic          cmd_rdy,
  output logic          cmd_bit,
  output logic [IW-1:0] cmd_idx,
  output logic          cmd_first,
  output logic          cmd_last,
  input  logic          step_done,
  output logic          busy,
  output logic          done,
  output logic          zero,
  output logic          err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  localparam logic [IW-1:0] IDX_MAX = IW'(N - 1);

  state_t        state_q, state_d;
  logic [N-1:0]  k_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [IW-1:0] msb_q, msb_d;
  logic          zero_q, zero_d;
  logic          err_q, err_d;

  logic          msb_oob;
  logic [IW-1:0] msb_clamp;
  logic          msb_bad;

  // Qualify the encoder result: out-of-range indices are clamped, and a
  // result that does not point at a set bit is flagged.
  always_comb begin
    msb_oob   = (msb > IDX_MAX);
    msb_clamp = msb_oob ? IDX_MAX : msb;
    msb_bad   = msb_oob || !k_q[msb_clamp];
  end

  // Next-state and datapath updates; abort outranks handshake and step_done.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    idx_d   = idx_q;
    msb_d   = msb_q;
    zero_d  = zero_q;
    err_d   = err_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          k_d     = k;
          err_d   = 1'b0;
          zero_d  = 1'b0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (k_q == '0) begin
          zero_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          zero_d  = 1'b0;
          idx_d   = msb_clamp;
          msb_d   = msb_clamp;
          if (msb_bad) begin
            err_d = 1'b1;
          end
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (cmd_rdy) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (step_done) begin
          if (idx_q == '0) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q - IW'(1);
            state_d = S_ISSUE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A completion pulse outside WAIT is a downstream protocol violation.
    if (step_done && (state_q != S_WAIT)) begin
      err_d = 1'b1;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      idx_q   <= '0;
      msb_q   <= '0;
      zero_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      idx_q   <= idx_d;
      msb_q   <= msb_d;
      zero_q  <= zero_d;
      err_q   <= err_d;
    end
  end

  // Outputs decode the registered state; cmd_* read zero outside ISSUE.
  always_comb begin
    enc_en    = (state_q == S_LOAD);
    cmd_vld   = (state_q == S_ISSUE);
    cmd_idx   = cmd_vld ? idx_q : '0;
    cmd_bit   = cmd_vld && k_q[idx_q];
    cmd_first = cmd_vld && (idx_q == msb_q);
    cmd_last  = cmd_vld && (idx_q == '0);
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
    zero      = zero_q;
    err       = err_q;
  end

endmodule

// File: tb/tb_scalar_ladder_seq.sv
// tb/tb_scalar_ladder_seq.sv - randomized self-checking bench for scalar_ladder_seq
module tb_scalar_ladder_seq;
  localparam int N  = 255;
  localparam int IW = 8;

  logic          clk = 1'b0;
  logic          rst, start, abort, cmd_rdy, step_done;
  logic [N-1:0]  k, k_q;
  logic          enc_en, cmd_vld, cmd_bit, cmd_first, cmd_last;
  logic          busy, done, zero, err;
  logic [IW-1:0] msb, cmd_idx;
  logic          ov_en;
  logic [IW-1:0] ov_val;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int idx;
    bit b;
    bit f;
    bit l;
  } cmd_t;

  always #5 clk = ~clk;

  scalar_ladder_seq #(.N(N), .IW(IW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .k         (k),
    .abort     (abort),
    .k_q       (k_q),
    .enc_en    (enc_en),
    .msb       (msb),
    .cmd_vld   (cmd_vld),
    .cmd_rdy   (cmd_rdy),
    .cmd_bit   (cmd_bit),
    .cmd_idx   (cmd_idx),
    .cmd_first (cmd_first),
    .cmd_last  (cmd_last),
    .step_done (step_done),
    .busy      (busy),
    .done      (done),
    .zero      (zero),
    .err       (err)
  );

  function automatic int top_bit(input logic [N-1:0] v);
    for (int i = N - 1; i >= 0; i--) begin
      if (v[i]) return i;
    end
    return 0;
  endfunction

  // Behavioural priority encoder, optionally overridden to inject a bad result.
  assign msb = ov_en ? ov_val : IW'(top_bit(k_q));

  function automatic logic [N-1:0] rand_k();
    logic [N-1:0] r;
    r = '0;
    repeat (8) r = {r[N-33:0], 32'($urandom)};
    return r;
  endfunction

  task automatic check_eq(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_k_q", k_q, '0);
    check_eq("rst_cmd_vld", cmd_vld, 0);
    check_eq("rst_cmd_bit", cmd_bit, 0);
    check_eq("rst_cmd_idx", cmd_idx, 0);
    check_eq("rst_cmd_first", cmd_first, 0);
    check_eq("rst_cmd_last", cmd_last, 0);
    check_eq("rst_enc_en", enc_en, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_zero", zero, 0);
    check_eq("rst_err", err, 0);
  endtask

  // One operation: called just after a falling edge, drives start immediately.
  // stall/dly < 0 pick random values per step; abort_at/rst_at < 0 disable.
  task automatic run_op(input logic [N-1:0] kk, input int stall, input int dly,
                        input int abort_at, input int rst_at, input bit noise,
                        input bit exp_err);
    cmd_t          obs[$];
    cmd_t          cur;
    logic [IW+2:0] snap;
    int c = 0, done_c = -1, last_sd = -1, first_vld = -1;
    int stall_left = 0, wcnt = 0, cur_idx = 0, top, n_exp, idx_e, n_cmp;
    bit in_cmd = 0, pending = 0, fired_abort = 0, fired_rst = 0;

    snap  = '0;
    start = 1'b1;
    k     = kk;
    while (done_c < 0) begin
      @(negedge clk);
      c++;
      start     = noise;
      k         = noise ? ~kk : kk;
      cmd_rdy   = 1'b0;
      step_done = 1'b0;
      abort     = 1'b0;
      if (c == 1) begin
        check_eq("enc_en_load", enc_en, 1);
        check_eq("err_cleared", err, 0);
        check_eq("busy_load", busy, 1);
      end
      if (c == 2) check_eq("enc_en_after", enc_en, 0);
      if (done) begin
        done_c = c;
        start  = 1'b0;
        k      = kk;
        check_eq("busy_at_done", busy, 1);
      end else if (cmd_vld) begin
        check_eq("vld_in_wait", pending, 0);
        if (first_vld < 0) first_vld = c;
        if (!in_cmd) begin
          in_cmd     = 1'b1;
          cur.idx    = int'(cmd_idx);
          cur.b      = cmd_bit;
          cur.f      = cmd_first;
          cur.l      = cmd_last;
          obs.push_back(cur);
          snap       = {cmd_idx, cmd_bit, cmd_first, cmd_last};
          stall_left = (stall < 0) ? int'($urandom_range(0, 3)) : stall;
        end else begin
          check_eq("cmd_stable", {cmd_idx, cmd_bit, cmd_first, cmd_last}, snap);
        end
        if (rst_at == int'(cmd_idx)) begin
          rst       = 1'b1;
          cmd_rdy   = 1'b1;
          fired_rst = 1'b1;
        end else if (stall_left == 0) begin
          cmd_rdy = 1'b1;
          in_cmd  = 1'b0;
          pending = 1'b1;
          cur_idx = int'(cmd_idx);
          wcnt    = (dly < 0) ? int'($urandom_range(0, 2)) : dly;
        end else begin
          stall_left--;
        end
      end else if (pending) begin
        if (wcnt == 0) begin
          step_done = 1'b1;
          pending   = 1'b0;
          last_sd   = c;
          if (abort_at == cur_idx) begin
            abort       = 1'b1;
            fired_abort = 1'b1;
          end
        end else begin
          wcnt--;
        end
      end
      if (fired_abort || fired_rst) break;
      if (c > 3000) begin
        check_eq("timeout", 1, 0);
        break;
      end
    end

    if (fired_rst) begin
      @(negedge clk);
      start = 1'b0; cmd_rdy = 1'b0; k = kk;
      check_reset_outputs();
      rst = 1'b0;
      return;
    end
    if (fired_abort) begin
      @(negedge clk);
      start = 1'b0; step_done = 1'b0; abort = 1'b0; k = kk;
      check_eq("abort_busy", busy, 0);
      check_eq("abort_vld", cmd_vld, 0);
      check_eq("abort_done", done, 0);
      check_eq("abort_err", err, 0);
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        check_eq("abort_no_done", done, 0);
      end
      return;
    end
    if (done_c < 0) return;

    top   = ov_en ? ((int'(ov_val) > N - 1) ? N - 1 : int'(ov_val)) : top_bit(kk);
    n_exp = (kk == '0) ? 0 : top + 1;
    check_eq("n_cmds", obs.size(), n_exp);
    n_cmp = (obs.size() < n_exp) ? obs.size() : n_exp;
    for (int j = 0; j < n_cmp; j++) begin
      idx_e = top - j;
      check_eq("cmd_idx", obs[j].idx, idx_e);
      check_eq("cmd_bit", obs[j].b, kk[idx_e]);
      check_eq("cmd_first", obs[j].f, (j == 0));
      check_eq("cmd_last", obs[j].l, (idx_e == 0));
    end
    check_eq("zero_flag", zero, (kk == '0));
    check_eq("k_q_latched", k_q, kk);
    check_eq("err_flag", err, exp_err);
    if (kk != '0) begin
      check_eq("done_after_step", done_c, last_sd + 1);
      check_eq("first_vld_cycle", first_vld, 2);
    end else begin
      check_eq("zero_done_cycle", done_c, 2);
      check_eq("zero_no_vld", first_vld, -1);
    end
    if (stall == 0 && dly == 0) check_eq("min_latency", done_c, 2 * n_exp + 2);
    @(negedge clk);
    check_eq("busy_after_done", busy, 0);
    check_eq("done_pulse", done, 0);
    check_eq("zero_hold", zero, (kk == '0));
  endtask

  initial begin
    logic [N-1:0] kr;
    int w;
    rst = 1'b1; start = 1'b0; abort = 1'b0; cmd_rdy = 1'b0; step_done = 1'b0;
    k = '0; ov_en = 1'b0; ov_val = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;
    @(negedge clk);
    check_eq("idle_busy", busy, 0);

    run_op(255'h1, 0, 0, -1, -1, 0, 0);
    run_op(255'h0, 0, 0, -1, -1, 0, 0);
    run_op(255'hB, 0, 0, -1, -1, 0, 0);
    kr = rand_k();
    kr[N-1] = 1'b1;
    run_op(kr, 3, 0, -1, -1, 0, 0);

    for (int t = 0; t < 8; t++) begin
      w  = int'($urandom_range(1, 24));
      kr = rand_k() & ((255'(1) << w) - 255'(1));
      run_op(kr, -1, -1, -1, -1, 1'($urandom_range(0, 1)), 0);
    end

    run_op(255'h3A5, 0, 0, 5, -1, 0, 0);
    run_op(255'hFF, 0, 0, -1, 2, 0, 0);
    run_op(255'h2D, 0, 0, -1, -1, 1, 0);

    step_done = 1'b1;
    @(negedge clk);
    step_done = 1'b0;
    check_eq("idle_step_err", err, 1);
    check_eq("idle_step_busy", busy, 0);
    run_op(255'h6, 0, 0, -1, -1, 0, 0);

    ov_en  = 1'b1;
    ov_val = 8'd1;
    run_op(255'h4, 0, 0, -1, -1, 0, 1);
    ov_val = 8'd255;
    run_op(255'h1, 0, 0, -1, -1, 0, 1);
    ov_en  = 1'b0;
    run_op(255'h9, -1, -1, -1, -1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/scalar_ladder_seq.md
# scalar_ladder_seq

Control sequencer for constant-width scalar multiplication. It latches a 255-bit scalar and drives the priority encoder with it to find the top set bit. It then walks the scalar from that bit down to bit 0, issuing one ladder-step command per bit to the downstream point-arithmetic unit. It sits between the scalar-input path and the ladder/point-op datapath, and owns step ordering, backpressure, and completion signalling.

## Interface
- N, 255, scalar width in bits
- IW, $clog2(N) (8), bit-index width; matches the priority encoder output

- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  one-cycle request; accepted only in IDLE
- k  in  N  scalar; sampled on the cycle start is accepted
- abort  in  1  synchronous cancel of an operation in progress
- k_q  out  N  latched scalar; drives the priority encoder `n` input
- enc_en  out  1  priority-encoder enable; high in LOAD only
- msb  in  IW  priority-encoder index result for k_q
- cmd_vld  out  1  ladder-step command valid
- cmd_rdy  in  1  point-op unit accepts the command
- cmd_bit  out  1  k_q[cmd_idx]; conditional-swap select for the ladder step
- cmd_idx  out  IW  bit index of this step
- cmd_first  out  1  this step is the first one (cmd_idx == msb)
- cmd_last  out  1  this step is the last one (cmd_idx == 0)
- step_done  in  1  one-cycle pulse: the accepted step has finished
- busy  out  1  operation in progress
- done  out  1  one-cycle completion pulse
- zero  out  1  valid with done: the scalar was 0 and no steps were issued
- err  out  1  sticky protocol error; cleared on accepted start

## Operation
- States: IDLE, LOAD, ISSUE, WAIT, DONE. Encoding is free.
- IDLE:
  - start=1 latches k into k_q, clears err, moves to LOAD.
  - start is ignored in every other state.
- LOAD:
  - enc_en=1 and msb is sampled; msb is combinational from k_q.
  - If k_q==0, go to DONE with zero=1.
  - Otherwise set idx=msb and zero=0, and go to ISSUE.
- ISSUE:
  - cmd_vld=1, cmd_idx=idx, cmd_bit=k_q[idx].
  - cmd_first=(idx==msb_q), where msb_q is the msb value registered in LOAD. cmd_last=(idx==0).
  - All cmd_* outputs hold stable until cmd_vld&&cmd_rdy, then the state moves to WAIT.
- WAIT:
  - cmd_vld=0. On step_done: if idx==0, go to DONE; else idx=idx-1 and go to ISSUE.
- DONE: done=1 for one cycle, then IDLE. zero holds its value until the next accepted start.
- abort in LOAD, ISSUE or WAIT:
  - Next state is IDLE, cmd_vld drops next cycle, no done pulse.
  - abort has priority over cmd_rdy and step_done in the same cycle.
- Errors, all set err and change no state:
  - step_done while not in WAIT.
  - msb > N-1 or k_q[msb]==0 sampled in LOAD with k_q!=0. For this case the block proceeds with msb clamped to N-1.
- Width rules:
  - idx is IW bits and decrements only when nonzero, so it never wraps.
  - Number of steps issued = msb+1.
- busy = (state != IDLE).

## Timing
- Reset values: state IDLE; k_q=0, idx=0, msb_q=0; cmd_vld=0, cmd_bit=0, cmd_idx=0, cmd_first=0, cmd_last=0; enc_en=0, busy=0, done=0, zero=0, err=0.
- rst mid-operation: the next cycle shows the reset values, with no done pulse. Any command already accepted downstream is the downstream unit's responsibility.
- Cycle schedule (start accepted in cycle 0):
  - LOAD in cycle 1.
  - First cmd_vld in cycle 2.
  - Zero scalar: done in cycle 2.
- Per step, minimum 2 cycles: the handshake cycle, then WAIT with step_done in the same cycle.
- Minimum total: start to done = 2·(msb+1)+2 cycles, with cmd_rdy tied high and step_done one cycle after each handshake.
- done is registered and asserted the cycle after the final step_done. busy falls the cycle after done.
- A new start is accepted the cycle after done returns to IDLE, so the earliest restart is cycle done+1.

## Test plan
- k=1 (msb=0): expect exactly one command: cmd_idx=0, cmd_bit=1, cmd_first=1, cmd_last=1. done arrives the cycle after step_done, with zero=0.
- k=0: no cmd_vld ever; done=1 in cycle 2 with zero=1; busy high in cycles 1-2 only.
- k=0xB (msb=3), cmd_rdy=1, step_done one cycle after each handshake:
  - cmd_idx sequence 3,2,1,0 with cmd_bit sequence 1,0,1,1.
  - cmd_first on idx 3 only, cmd_last on idx 0 only.
  - done at cycle 10.
- k with bit 254 set, cmd_rdy low for 3 cycles on every step:
  - cmd_* stays stable while stalled.
  - 255 commands issued, the first with cmd_idx=254.
- Disturbances:
  - abort during WAIT of step idx 5 → IDLE next cycle, no done.
  - rst during ISSUE → all outputs at their reset values next cycle.
  - start while busy → ignored.
  - step_done pulse in IDLE → err=1, which clears on the next accepted start.
